player_key_ctrl: RTL and testbench

PLAYER_KEY_CTRL -- requirements
Module: player_key_ctrl

---
 rtl/player_key_ctrl.sv | 148 ++++++++++++++
 tb/tb_player_key_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/player_key_ctrl.sv
// Keyboard-to-player control: turns make/brakk scan-code strobes into frame-aligned,
// active-low move requests and rate-limited one-clock fire pulses.
module player_key_ctrl #(
    parameter logic [8:0] KEY_LEFT             = 9'h06B,
    parameter logic [8:0] KEY_RIGHT            = 9'h074,
    parameter logic [8:0] KEY_FIRE             = 9'h029,
    parameter int         FIRE_COOLDOWN_FRAMES = 8,
    parameter int         HOLD_TIMEOUT_FRAMES  = 30
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic [8:0] keyCode,
    input  logic       make,
    input  logic       brakk,
    output logic       moveLeft,
    output logic       moveRight,
    output logic       firePulse
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TIMEOUT_FRAMES - 1);
    localparam logic [7:0] COOL_LOAD = 8'(FIRE_COOLDOWN_FRAMES);

    logic       left_held;
    logic       right_held;
    logic       fire_held;
    logic       last_dir;
    logic       fire_pending;
    logic [7:0] left_cnt;
    logic [7:0] right_cnt;
    logic [7:0] cooldown;

    logic key_dn;
    logic key_up;
    logic left_dn;
    logic left_up;
    logic right_dn;
    logic right_up;
    logic fire_dn;
    logic fire_up;
    logic fire_now;
    logic left_nxt;
    logic right_nxt;

    // A cycle with both strobes high carries no usable event, so it decodes to nothing.
    assign key_dn   = make & ~brakk;
    assign key_up   = brakk & ~make;
    assign left_dn  = key_dn && (keyCode == KEY_LEFT);
    assign left_up  = key_up && (keyCode == KEY_LEFT);
    assign right_dn = key_dn && (keyCode == KEY_RIGHT);
    assign right_up = key_up && (keyCode == KEY_RIGHT);
    assign fire_dn  = key_dn && (keyCode == KEY_FIRE);
    assign fire_up  = key_up && (keyCode == KEY_FIRE);

    assign fire_now = startOfFrame && fire_pending && (cooldown == 8'd0);

    always_comb begin
        left_nxt  = 1'b1;
        right_nxt = 1'b1;
        case ({left_held, right_held})
            2'b10:   left_nxt  = 1'b0;
            2'b01:   right_nxt = 1'b0;
            2'b11: begin
                if (last_dir) right_nxt = 1'b0;
                else          left_nxt  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            left_held  <= 1'b0;
            right_held <= 1'b0;
            left_cnt   <= 8'd0;
            right_cnt  <= 8'd0;
            last_dir   <= 1'b0;
            moveLeft   <= 1'b1;
            moveRight  <= 1'b1;
        end else begin
            if (left_dn) begin
                left_held <= 1'b1;
                left_cnt  <= 8'd0;
            end else if (left_up) begin
                left_held <= 1'b0;
                left_cnt  <= 8'd0;
            end else if (startOfFrame && left_held) begin
                if (left_cnt == HOLD_LAST) begin
                    left_held <= 1'b0;
                    left_cnt  <= 8'd0;
                end else begin
                    left_cnt  <= left_cnt + 8'd1;
                end
            end

            if (right_dn) begin
                right_held <= 1'b1;
                right_cnt  <= 8'd0;
            end else if (right_up) begin
                right_held <= 1'b0;
                right_cnt  <= 8'd0;
            end else if (startOfFrame && right_held) begin
                if (right_cnt == HOLD_LAST) begin
                    right_held <= 1'b0;
                    right_cnt  <= 8'd0;
                end else begin
                    right_cnt  <= right_cnt + 8'd1;
                end
            end

            if (left_dn)       last_dir <= 1'b0;
            else if (right_dn) last_dir <= 1'b1;

            // Outputs sample the flags as they stood before this edge.
            if (startOfFrame) begin
                moveLeft  <= left_nxt;
                moveRight <= right_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fire_held    <= 1'b0;
            fire_pending <= 1'b0;
            cooldown     <= 8'd0;
            firePulse    <= 1'b0;
        end else begin
            firePulse <= fire_now;

            if (fire_now) begin
                fire_pending <= 1'b0;
                cooldown     <= COOL_LOAD;
            end else if (startOfFrame && (cooldown != 8'd0)) begin
                cooldown     <= cooldown - 8'd1;
            end

            // A fresh press only counts when no cooldown is running, including one starting now.
            if (fire_dn && !fire_held) begin
                fire_held <= 1'b1;
                if ((cooldown == 8'd0) && !fire_now) fire_pending <= 1'b1;
            end else if (fire_up) begin
                fire_held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_player_key_ctrl.sv
// Scoreboard bench for player_key_ctrl: per-frame expectations are queued with the
// stimulus and compared right after each startOfFrame edge.
module tb_player_key_ctrl;

    localparam logic [8:0] K_LEFT  = 9'h06B;
    localparam logic [8:0] K_RIGHT = 9'h074;
    localparam logic [8:0] K_FIRE  = 9'h029;
    localparam logic [8:0] K_OTHER = 9'h01C;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic [8:0] keyCode;
    logic       make;
    logic       brakk;
    logic       moveLeft;
    logic       moveRight;
    logic       firePulse;

    typedef struct packed {
        logic ml;
        logic mr;
        logic fp;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   frame_no = 0;

    player_key_ctrl #(
        .KEY_LEFT(K_LEFT),
        .KEY_RIGHT(K_RIGHT),
        .KEY_FIRE(K_FIRE),
        .FIRE_COOLDOWN_FRAMES(8),
        .HOLD_TIMEOUT_FRAMES(30)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .keyCode(keyCode),
        .make(make),
        .brakk(brakk),
        .moveLeft(moveLeft),
        .moveRight(moveRight),
        .firePulse(firePulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic ml, input logic mr, input logic fp);
        exp_t e;
        e.ml = ml;
        e.mr = mr;
        e.fp = fp;
        exp_q.push_back(e);
    endtask

    task automatic strobe(input logic mk, input logic brk, input logic [8:0] code);
        @(negedge clk);
        make = mk; brakk = brk; keyCode = code;
        @(negedge clk);
        make = 1'b0; brakk = 1'b0; keyCode = '0;
    endtask

    task automatic frame_ev(input logic mk, input logic brk, input logic [8:0] code);
        exp_t e;
        @(negedge clk);
        startOfFrame = 1'b1;
        make = mk; brakk = brk; keyCode = code;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        make = 1'b0; brakk = 1'b0; keyCode = '0;
        frame_no++;
        if (exp_q.size() == 0) begin
            check_val($sformatf("f%0d_sb_empty", frame_no), 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val($sformatf("f%0d_moveLeft", frame_no), 32'(moveLeft), 32'(e.ml));
            check_val($sformatf("f%0d_moveRight", frame_no), 32'(moveRight), 32'(e.mr));
            check_val($sformatf("f%0d_firePulse", frame_no), 32'(firePulse), 32'(e.fp));
            @(posedge clk);
            #1;
            check_val($sformatf("f%0d_fire_width", frame_no), 32'(firePulse), 32'd0);
            check_val($sformatf("f%0d_hold_ml", frame_no), 32'(moveLeft), 32'(e.ml));
            check_val($sformatf("f%0d_hold_mr", frame_no), 32'(moveRight), 32'(e.mr));
        end
        @(posedge clk);
    endtask

    task automatic frame();
        frame_ev(1'b0, 1'b0, 9'h000);
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0;
        keyCode = '0;
        make = 1'b0;
        brakk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_moveLeft", 32'(moveLeft), 32'd1);
        check_val("rst_moveRight", 32'(moveRight), 32'd1);
        check_val("rst_firePulse", 32'(firePulse), 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        push(1, 1, 0); frame();

        // Left press mid-frame: visible only from the next frame edge.
        strobe(1, 0, K_LEFT);
        repeat (2) @(posedge clk);
        #1;
        check_val("pre_sof_moveLeft", 32'(moveLeft), 32'd1);
        check_val("pre_sof_moveRight", 32'(moveRight), 32'd1);
        push(0, 1, 0); frame();

        // Left held, right pressed then released, then last-direction cases.
        strobe(1, 0, K_RIGHT); push(1, 0, 0); frame();
        strobe(0, 1, K_RIGHT); push(0, 1, 0); frame();
        strobe(1, 0, K_RIGHT); push(1, 0, 0); frame();
        strobe(1, 0, K_LEFT);  push(0, 1, 0); frame();
        strobe(0, 1, K_LEFT);  push(1, 0, 0); frame();
        strobe(0, 1, K_RIGHT); push(1, 1, 0); frame();

        // Simultaneous make/brakk and unknown codes change nothing.
        strobe(1, 1, K_LEFT);  push(1, 1, 0); frame();
        strobe(1, 0, K_OTHER); push(1, 1, 0); frame();

        // Events coinciding with startOfFrame land one frame later.
        push(1, 1, 0); frame_ev(1, 0, K_RIGHT);
        push(1, 0, 0); frame();
        push(1, 0, 0); frame_ev(0, 1, K_RIGHT);
        push(1, 1, 0); frame();

        // Single right press, no repeat: 30 frames active, released on the 31st.
        strobe(1, 0, K_RIGHT);
        for (int i = 0; i < 30; i++) begin
            push(1, 0, 0); frame();
        end
        push(1, 1, 0); frame();
        push(1, 1, 0); frame();

        // Fire cooldown: second press during cooldown is dropped.
        strobe(1, 0, K_FIRE); strobe(0, 1, K_FIRE);
        push(1, 1, 1); frame();
        for (int i = 0; i < 2; i++) begin
            push(1, 1, 0); frame();
        end
        strobe(1, 0, K_FIRE); strobe(0, 1, K_FIRE);
        for (int i = 0; i < 7; i++) begin
            push(1, 1, 0); frame();
        end
        strobe(1, 0, K_FIRE); strobe(0, 1, K_FIRE);
        push(1, 1, 1); frame();
        for (int i = 0; i < 8; i++) begin
            push(1, 1, 0); frame();
        end

        // Typematic repeats of fire without release give one pulse only.
        strobe(1, 0, K_FIRE);
        push(1, 1, 1); frame();
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 1) strobe(1, 0, K_FIRE);
            push(1, 1, 0); frame();
        end
        strobe(0, 1, K_FIRE);
        push(1, 1, 0); frame();

        // Reset with left held and cooldown at 5.
        strobe(1, 0, K_LEFT);
        strobe(1, 0, K_FIRE); strobe(0, 1, K_FIRE);
        push(0, 1, 1); frame();
        for (int i = 0; i < 3; i++) begin
            push(0, 1, 0); frame();
        end
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check_val("async_rst_moveLeft", 32'(moveLeft), 32'd1);
        check_val("async_rst_moveRight", 32'(moveRight), 32'd1);
        check_val("async_rst_firePulse", 32'(firePulse), 32'd0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        strobe(1, 0, K_FIRE); strobe(0, 1, K_FIRE);
        push(1, 1, 1); frame();
        push(1, 1, 0); frame();

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
